// File: rtl/dmem_bus_if.sv
// Data-memory bus adapter: turns a pipeline load/store into one request/response bus access.
// Latency: at least 3 cycles from request to DONE; each extra cycle of grant or response wait adds one.
// Backpressure: stall holds the pipeline while the access is outstanding; aborts after TIMEOUT cycles.
module dmem_bus_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  maskByte,
  output logic [31:0] dataMemOut,
  output logic        stall,
  output logic        busError,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  // Counter is wide enough for TIMEOUT but never narrower than 8 bits.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic          complete;
  logic          abort;
  logic          expired;

  // A store with no byte enables is a misaligned store and never reaches the bus.
  assign accept  = (read | write) & (~write | (maskByte != 4'b0000));
  assign cnt_inc = cnt + 1'b1;
  assign expired = (cnt_inc >= CW'(TIMEOUT));

  // Next-state and stall; a grant without a response wins over the timeout, WAIT then aborts.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_gnt && bus_rvalid) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (bus_gnt) begin
          state_nxt = WAIT;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, latched bus request fields and the returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dataMemOut <= 32'h0;
      busError   <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= 4'b0000;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
    end else begin
      state    <= state_nxt;
      bus_req  <= (state_nxt == REQ);
      busError <= abort;
      if (state == IDLE) begin
        cnt <= '0;
        if (accept) begin
          bus_we    <= write;
          bus_be    <= write ? maskByte : 4'b1111;
          bus_addr  <= {address[31:2], 2'b00};
          bus_wdata <= writeData << {address[1:0], 3'b000};
        end
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt_inc;
      end
      if (complete && !bus_we) begin
        dataMemOut <= bus_rdata;
      end else if (abort) begin
        dataMemOut <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Bench for dmem_bus_if: directed load/store sequences plus a scoreboard on the returned word.
// Two instances: default TIMEOUT for the normal accesses, TIMEOUT=4 for the abort case.
// Inputs are driven just after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, writeData, bus_rdata;
  logic        read, write, bus_gnt, bus_rvalid;
  logic [3:0]  maskByte;

  logic [31:0] dataMemOut, bus_addr, bus_wdata;
  logic        stall, busError, bus_req, bus_we;
  logic [3:0]  bus_be;

  logic [31:0] to_dataMemOut, to_bus_addr, to_bus_wdata;
  logic        to_stall, to_busError, to_bus_req, to_bus_we;
  logic [3:0]  to_bus_be;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_dmem;
  logic        prev_stall = 1'b0;

  always #5 clk = ~clk;

  dmem_bus_if u_dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .read(read), .write(write), .maskByte(maskByte),
    .dataMemOut(dataMemOut), .stall(stall), .busError(busError),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  dmem_bus_if #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .read(read), .write(write), .maskByte(maskByte),
    .dataMemOut(to_dataMemOut), .stall(to_stall), .busError(to_busError),
    .bus_req(to_bus_req), .bus_we(to_bus_we), .bus_addr(to_bus_addr),
    .bus_be(to_bus_be), .bus_wdata(to_bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_in();
    read = 1'b0; write = 1'b0; maskByte = 4'b0000; writeData = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
  endtask

  // Scoreboard: every falling edge of stall on the main instance retires one expected word.
  always @(negedge clk) begin
    if (prev_stall === 1'b1 && stall === 1'b0) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("sb_dmem", dataMemOut, sb.pop_front());
    end
    prev_stall = stall;
  end

  // Store granted and acknowledged in the same cycle; returned word must not change.
  task automatic zw_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                          input logic rd_too);
    logic [31:0] e_wd;
    e_wd = wd << (8 * a[1:0]);
    sb.push_back(exp_dmem);
    address = a; writeData = wd; maskByte = m; write = 1'b1; read = rd_too;
    at_neg(); chk("st_c0_stall", {31'b0, stall}, 32'd1);
    cyc();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BADF00D;
    at_neg();
    chk("st_req", {31'b0, bus_req}, 32'd1);
    chk("st_we", {31'b0, bus_we}, 32'd1);
    chk("st_be", {28'b0, bus_be}, {28'b0, m});
    chk("st_wdata", bus_wdata, e_wd);
    chk("st_addr", bus_addr, {a[31:2], 2'b00});
    cyc();
    idle_in();
    at_neg();
    chk("st_done_stall", {31'b0, stall}, 32'd0);
    chk("st_done_req", {31'b0, bus_req}, 32'd0);
    chk("st_done_dmem", dataMemOut, exp_dmem);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_in();
    address = 32'h0;
    rst = 1'b1;
    cyc(); cyc();
    at_neg();
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_we", {31'b0, bus_we}, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_dmem", dataMemOut, 32'd0);
    chk("rst_berr", {31'b0, busError}, 32'd0);
    cyc();
    rst = 1'b0;

    // Load at 0x1002: grant in cycle 2, response in cycle 4, DONE in cycle 5.
    exp_dmem = 32'hDEADBEEF;
    sb.push_back(exp_dmem);
    address = 32'h1002; read = 1'b1;
    at_neg(); chk("rd_c0_stall", {31'b0, stall}, 32'd1); chk("rd_c0_req", {31'b0, bus_req}, 32'd0);
    cyc();
    at_neg();
    chk("rd_c1_req", {31'b0, bus_req}, 32'd1);
    chk("rd_c1_addr", bus_addr, 32'h1000);
    chk("rd_c1_be", {28'b0, bus_be}, 32'hF);
    chk("rd_c1_we", {31'b0, bus_we}, 32'd0);
    cyc();
    bus_gnt = 1'b1;
    at_neg(); chk("rd_c2_stall", {31'b0, stall}, 32'd1); chk("rd_c2_req", {31'b0, bus_req}, 32'd1);
    cyc();
    bus_gnt = 1'b0;
    at_neg(); chk("rd_c3_req", {31'b0, bus_req}, 32'd0); chk("rd_c3_stall", {31'b0, stall}, 32'd1);
    cyc();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    at_neg(); chk("rd_c4_stall", {31'b0, stall}, 32'd1);
    cyc();
    idle_in();
    at_neg();
    chk("rd_c5_stall", {31'b0, stall}, 32'd0);
    chk("rd_c5_berr", {31'b0, busError}, 32'd0);
    chk("rd_c5_dmem", dataMemOut, 32'hDEADBEEF);
    cyc();
    at_neg(); chk("rd_c6_stall", {31'b0, stall}, 32'd0);
    cyc();

    // Byte, halfword, and read+write (treated as a store) with lane shifting.
    zw_store(32'h2003, 32'h000000A5, 4'b1000, 1'b0);
    zw_store(32'h2002, 32'h1234BEEF, 4'b1100, 1'b0);
    zw_store(32'h6001, 32'h00000077, 4'b0010, 1'b1);

    // Misaligned store never reaches the bus; stray gnt/rvalid in IDLE are ignored.
    address = 32'h3001; write = 1'b1; maskByte = 4'b0000; writeData = 32'h55;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    at_neg(); chk("mis_stall", {31'b0, stall}, 32'd0);
    cyc();
    at_neg();
    chk("mis_req", {31'b0, bus_req}, 32'd0);
    chk("mis_stall2", {31'b0, stall}, 32'd0);
    chk("mis_dmem", dataMemOut, exp_dmem);
    cyc();
    idle_in();

    // Reset while in WAIT, then a late response that must be ignored.
    address = 32'h5000; read = 1'b1;
    cyc();
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0; rst = 1'b1;
    sb.push_back(32'h0);
    at_neg(); chk("rw_wait_stall", {31'b0, stall}, 32'd1);
    cyc();
    rst = 1'b0; read = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    at_neg();
    chk("rw_stall", {31'b0, stall}, 32'd0);
    chk("rw_req", {31'b0, bus_req}, 32'd0);
    chk("rw_dmem", dataMemOut, 32'h0);
    cyc();
    bus_rvalid = 1'b0;
    at_neg(); chk("rw_dmem2", dataMemOut, 32'h0); chk("rw_stall2", {31'b0, stall}, 32'd0);
    cyc();

    // Timeout on the TIMEOUT=4 instance; preload a nonzero word first.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_dmem = 32'h12345678;
    sb.push_back(exp_dmem);
    address = 32'h4000; read = 1'b1;
    cyc();
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    cyc();
    idle_in();
    at_neg(); chk("to_pre_dmem", to_dataMemOut, 32'h12345678); chk("to_pre_stall", {31'b0, to_stall}, 32'd0);
    cyc();
    address = 32'h4004; read = 1'b1;
    at_neg(); chk("to_c0_stall", {31'b0, to_stall}, 32'd1);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      at_neg();
      chk($sformatf("to_c%0d_req", i), {31'b0, to_bus_req}, 32'd1);
      chk($sformatf("to_c%0d_berr", i), {31'b0, to_busError}, 32'd0);
      cyc();
    end
    read = 1'b0;
    at_neg();
    chk("to_done_berr", {31'b0, to_busError}, 32'd1);
    chk("to_done_dmem", to_dataMemOut, 32'h0);
    chk("to_done_req", {31'b0, to_bus_req}, 32'd0);
    chk("to_done_stall", {31'b0, to_stall}, 32'd0);
    cyc();
    at_neg(); chk("to_after_berr", {31'b0, to_busError}, 32'd0);
    cyc();

    // Main instance is still waiting for a grant; reset releases it.
    rst = 1'b1;
    sb.push_back(32'h0);
    cyc();
    rst = 1'b0;
    at_neg(); chk("end_stall", {31'b0, stall}, 32'd0);
    cyc();

    chk("sb_left", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
